// File: rtl/dac_pkg.sv
// dac_pkg: shared widths, unity gain constant and ramp state type for the DAC soft-mute stage
package dac_pkg;
    localparam int SAMPLE_W   = 16;
    localparam int GAIN_W     = 12;
    localparam int GAIN_UNITY = 2048;
    typedef enum logic [1:0] {MUTED, RAMP_UP, UNMUTED, RAMP_DOWN} state_e;
endpackage

// File: rtl/soft_mute_lane_mult.sv
// soft_mute_lane_mult: one lane's 2-stage sample x Q1.11 gain multiply with floor shift back to sample width
module soft_mute_lane_mult #(
    parameter int SAMPLE_W = 16,
    parameter int GAIN_W   = 12
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic signed [SAMPLE_W-1:0] sample_i,
    input  logic        [GAIN_W-1:0]   gain_i,
    output logic signed [SAMPLE_W-1:0] dout_o
);
    localparam int PW = SAMPLE_W + GAIN_W + 1;
    logic signed [PW-1:0] prod_q;
    // stage 1 holds the full-width product; stage 2 drops the Q1.11 fraction (gain <= unity so no overflow)
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prod_q <= '0;
            dout_o <= '0;
        end else begin
            prod_q <= PW'(sample_i) * PW'($signed({1'b0, gain_i}));
            dout_o <= SAMPLE_W'(prod_q >>> (GAIN_W - 1));
        end
    end
endmodule

// File: rtl/dac_soft_mute.sv
// dac_soft_mute: click-free mute/unmute gain ramp over a word of signed samples; DAC_SOFT_MUTE_PEAK_DETECT_EN adds peak_hold
module dac_soft_mute
    import dac_pkg::*;
#(
    parameter int LANES    = 8,
    parameter int SAMPLE_W = dac_pkg::SAMPLE_W,
    parameter int GAIN_W   = dac_pkg::GAIN_W
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [GAIN_W-1:0]         ramp_step,
    input  logic [LANES*SAMPLE_W-1:0] din,
    input  logic                      din_valid,
    output logic [LANES*SAMPLE_W-1:0] dout,
    output logic                      dout_valid,
    output logic                      muted,
    output logic                      ramp_busy
`ifdef DAC_SOFT_MUTE_PEAK_DETECT_EN
    ,
    output logic                      peak_hold
`endif
);
    localparam logic [GAIN_W:0] UNITY = (GAIN_W + 1)'(GAIN_UNITY);
    state_e            state_q, state_d;
    logic [GAIN_W-1:0] gain_q, gain_d;
    logic [GAIN_W:0]   step, up, dn;
    logic [1:0]        valid_q;
    // saturating up/down gain candidates; enable picks direction, so reversals continue from the current gain
    always_comb begin
        step    = (ramp_step == '0) ? {{GAIN_W{1'b0}}, 1'b1} : {1'b0, ramp_step};
        up      = ({1'b0, gain_q} + step >= UNITY) ? UNITY : {1'b0, gain_q} + step;
        dn      = ({1'b0, gain_q} <= step) ? '0 : {1'b0, gain_q} - step;
        gain_d  = gain_q;
        state_d = state_q;
        if (din_valid) begin
            gain_d  = enable ? GAIN_W'(up) : GAIN_W'(dn);
            state_d = enable ? ((up == UNITY) ? UNMUTED : RAMP_UP)
                             : ((dn == '0) ? MUTED : RAMP_DOWN);
        end
    end
    // ramp state, gain and valid delay line
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= MUTED;
            gain_q  <= '0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            gain_q  <= gain_d;
            valid_q <= {valid_q[0], din_valid};
        end
    end
    assign dout_valid = valid_q[1];
    assign muted      = (state_q == MUTED);
    assign ramp_busy  = (state_q == RAMP_UP) || (state_q == RAMP_DOWN);
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        soft_mute_lane_mult #(.SAMPLE_W(SAMPLE_W), .GAIN_W(GAIN_W)) u_mult (
            .clock   (clock),
            .reset   (reset),
            .sample_i(din[k*SAMPLE_W +: SAMPLE_W]),
            .gain_i  (gain_q),
            .dout_o  (dout[k*SAMPLE_W +: SAMPLE_W])
        );
    end
`ifdef DAC_SOFT_MUTE_PEAK_DETECT_EN
    logic en_q, peak_hit;
    // any lane of the current output word sitting at full scale
    always_comb begin
        peak_hit = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            peak_hit = peak_hit
                | (dout[k*SAMPLE_W +: SAMPLE_W] == {1'b0, {(SAMPLE_W-1){1'b1}}})
                | (dout[k*SAMPLE_W +: SAMPLE_W] == {1'b1, {(SAMPLE_W-1){1'b0}}});
        end
    end
    // sticky flag, re-armed by each unmute request
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            en_q      <= 1'b0;
            peak_hold <= 1'b0;
        end else begin
            en_q      <= enable;
            peak_hold <= (enable & ~en_q) ? 1'b0 : (peak_hold | (dout_valid & peak_hit));
        end
    end
`endif
endmodule
